// File: rtl/data_mem_if.sv
// Core-side bus of the data-memory controller.
// Handshake: the core raises memread or memwrite (memwrite wins if both are
// high) together with addr/write_data/sign_mask; the controller samples them
// while idle and raises clk_stall on the following cycle. The core must hold
// the pipeline while clk_stall=1. The access is complete on the first cycle
// that clk_stall returns to 0; read_data is then valid and holds until the
// next completed load. Requests presented while the controller is busy are
// ignored.
interface data_mem_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;
  logic        fault;

  modport master (
    output addr, write_data, memwrite, memread, sign_mask,
    input  read_data, clk_stall, fault
  );

  modport slave (
    input  addr, write_data, memwrite, memread, sign_mask,
    output read_data, clk_stall, fault
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller for the RV32I pipeline: byte/half/word loads and
// stores into block RAM, a memory-mapped LED register, and a sticky fault
// flag for misaligned, unmapped or badly sized accesses.
// Every access stalls the core for exactly three cycles:
//   IDLE (sample request) -> FETCH x2 (RAM address cycle, RAM data cycle)
//   -> LOAD or STORE (result / write-back) -> IDLE.
// INIT_FILE names the RAM image for the build flow; the controller itself
// never clears or preloads RAM, so contents survive reset.
module data_mem_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] DATA_BASE   = 32'h0000_4000,
  parameter logic [31:0] LED_ADDR    = 32'h0000_2000,
  parameter int          LED_WIDTH   = 8,
  parameter string       INIT_FILE   = "verilog/data.hex"
) (
  input  logic                 clk,
  input  logic                 reset_n,
  data_mem_if.slave            bus,
  output logic [LED_WIDTH-1:0] led,
  output logic [1:0]           dbg_state
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_STORE = 2'd3
  } state_t;

  state_t state, state_next;
  logic   fetch_phase, fetch_phase_next;

  // Request captured while idle; stable for the rest of the access.
  logic [31:0] addr_buf;
  logic [31:0] wdata_buf;
  logic [3:0]  mask_buf;
  logic        write_buf;

  logic [31:0] word_buf;
  logic        bad_buf;
  logic [31:0] read_data_q;
  logic        stall_q;
  logic        fault_q;
  logic [LED_WIDTH-1:0] led_q;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_word;

  // Address / size decode of the captured request.
  logic [31:0]   offset;
  logic          in_ram;
  logic          is_led;
  logic [AW-1:0] ram_idx;
  logic          sz_byte, sz_half, sz_word, size_ok, misalign, bad_access;

  assign offset  = addr_buf - DATA_BASE;
  assign in_ram  = offset < RAM_BYTES;
  assign is_led  = addr_buf == LED_ADDR;
  assign ram_idx = offset[AW+1:2];

  assign sz_byte  = mask_buf[2:0] == 3'b001;
  assign sz_half  = mask_buf[2:0] == 3'b011;
  assign sz_word  = mask_buf[2:0] == 3'b111;
  assign size_ok  = sz_byte | sz_half | sz_word;
  assign misalign = (sz_half & addr_buf[0]) | (sz_word & (addr_buf[1:0] != 2'b00));
  // LED register accepts word accesses only.
  assign bad_access = !size_ok | misalign | !(in_ram | (is_led & sz_word));

  // Load extraction: shift the addressed lane(s) down, then extend.
  logic [31:0] byte_shifted, half_shifted, load_value;
  logic        sx;

  assign sx           = mask_buf[3];
  assign byte_shifted = word_buf >> {addr_buf[1:0], 3'b000};
  assign half_shifted = word_buf >> {addr_buf[1], 4'b0000};

  // Build the extended load result for the captured size.
  always_comb begin
    load_value = word_buf;
    if (sz_byte) begin
      load_value = {{24{sx & byte_shifted[7]}}, byte_shifted[7:0]};
    end else if (sz_half) begin
      load_value = {{16{sx & half_shifted[15]}}, half_shifted[15:0]};
    end
  end

  // Store merge: replicate the data across lanes, enable only addressed lanes.
  logic [3:0]  lane_en;
  logic [31:0] store_aligned, store_word;

  // Compute lane enables and the merged word written back to RAM.
  always_comb begin
    lane_en       = 4'b1111;
    store_aligned = wdata_buf;
    if (sz_byte) begin
      lane_en       = 4'b0001 << addr_buf[1:0];
      store_aligned = {4{wdata_buf[7:0]}};
    end else if (sz_half) begin
      lane_en       = addr_buf[1] ? 4'b1100 : 4'b0011;
      store_aligned = {2{wdata_buf[15:0]}};
    end
    for (int i = 0; i < 4; i++) begin
      store_word[8*i +: 8] = lane_en[i] ? store_aligned[8*i +: 8] : word_buf[8*i +: 8];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      fetch_phase <= 1'b0;
    end else begin
      state       <= state_next;
      fetch_phase <= fetch_phase_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next       = state;
    fetch_phase_next = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.memread || bus.memwrite) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_phase) begin
          state_next = write_buf ? S_STORE : S_LOAD;
        end else begin
          fetch_phase_next = 1'b1;
        end
      end
      S_LOAD:  state_next = S_IDLE;
      S_STORE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: request capture, word fetch, load result, LED and fault update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_buf    <= '0;
      wdata_buf   <= '0;
      mask_buf    <= '0;
      write_buf   <= 1'b0;
      word_buf    <= '0;
      bad_buf     <= 1'b0;
      read_data_q <= '0;
      stall_q     <= 1'b0;
      fault_q     <= 1'b0;
      led_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          addr_buf  <= bus.addr;
          wdata_buf <= bus.write_data;
          mask_buf  <= bus.sign_mask;
          write_buf <= bus.memwrite;
          if (bus.memread || bus.memwrite) stall_q <= 1'b1;
        end
        S_FETCH: begin
          if (fetch_phase) begin
            word_buf <= is_led ? 32'(led_q) : rd_word;
            bad_buf  <= bad_access;
          end
        end
        S_LOAD: begin
          read_data_q <= bad_buf ? 32'h0 : load_value;
          stall_q     <= 1'b0;
          if (bad_buf) fault_q <= 1'b1;
        end
        S_STORE: begin
          stall_q <= 1'b0;
          if (bad_buf) begin
            fault_q <= 1'b1;
          end else if (is_led) begin
            led_q <= wdata_buf[LED_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Block RAM: registered read every cycle, write-back only in a clean STORE.
  always_ff @(posedge clk) begin
    rd_word <= mem[ram_idx];
    if (reset_n && state == S_STORE && !bad_buf && in_ram) begin
      mem[ram_idx] <= store_word;
    end
  end

  assign bus.read_data = read_data_q;
  assign bus.clk_stall = stall_q;
  assign bus.fault     = fault_q;
  assign led           = led_q;
  assign dbg_state     = state;

endmodule
